reg_file: RTL and testbench

Architectural integer register file for the single-cycle RISC-V core: 31 writable 32-bit registers plus hardwired x0. Feeds the ALU operand path (rd1 becomes SrcA; rd2 becomes SrcB via the ALUSrc mux) and accepts the write-back result (ALUResult or load data) at the clock edge. After reset, a sequential clear sweep zeroes every register, one per cycle. `ready` gates the core until the sweep completes.

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/reg_file_clr_fsm.sv | 58 +++++
 rtl/reg_file.sv | 97 +++++++++
 tb/tb_reg_file.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the architectural register file.
// Holds the default widths, the clear-sweep state type and the x0 index.
package reg_file_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Clear sweep runs first, then the register file serves the core.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // x0 is hardwired to zero and has no storage behind it.
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  // True when a register index names real storage (anything but x0).
  function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
    is_writable = (addr != X0);
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_clr_fsm.sv
// Post-reset clear sequencer for reg_file.
// Walks the index from 1 up to NREG-1, zeroing one register per cycle,
// then raises ready. A reset at any time restarts the sweep from index 1.
module reg_file_clr_fsm #(
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    clr_we,
  output logic [$clog2(NREG)-1:0] clr_addr,
  output logic                    ready
);
  import reg_file_pkg::*;

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

  state_t          state_r;
  logic [AW-1:0]   idx_r;
  logic            ready_r;

  // Sweep state, index and ready flag; the last index hands over to RUN
  // without incrementing so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      idx_r   <= FIRST_IDX;
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          if (idx_r == LAST_IDX) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            idx_r   <= idx_r + AW'(1);
            ready_r <= 1'b0;
          end
        end
        RUN: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= CLEAR;
          idx_r   <= FIRST_IDX;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Clear write port is driven straight from registered state.
  assign clr_we   = (state_r == CLEAR);
  assign clr_addr = idx_r;
  assign ready    = ready_r;

endmodule : reg_file_clr_fsm

// File: rtl/reg_file.sv
// Architectural integer register file: 31 writable registers plus x0.
// Two combinational read ports, one edge-triggered write port, and a
// post-reset clear sweep that gates reads and writes until it completes.
// Optional macro REG_FILE_BYPASS_EN adds same-cycle write-through
// forwarding; the default build returns stored contents only.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] a1,
  input  logic [$clog2(NREG)-1:0] a2,
  input  logic [$clog2(NREG)-1:0] a3,
  input  logic                    we3,
  input  logic [DATA_W-1:0]       wd3,
  output logic [DATA_W-1:0]       rd1,
  output logic [DATA_W-1:0]       rd2,
  output logic                    ready
);
  import reg_file_pkg::*;

  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0] regs_r [1:NREG-1];

  logic              clr_we_s;
  logic [AW-1:0]     clr_addr_s;
  logic              ready_s;
  logic              read_en_s;
  logic              wr_en_s;

  reg_file_clr_fsm #(
    .NREG (NREG)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s),
    .ready    (ready_s)
  );

  assign ready = ready_s;

  // Reads are only meaningful once the sweep is done and reset is low.
  assign read_en_s = ready_s & ~rst;

  // Architectural write: RUN only, never to x0, never while in reset.
  assign wr_en_s = we3 & is_writable(a3) & read_en_s;

  // Storage write port: the clear sweep owns it while clearing, so a
  // core write during CLEAR is simply dropped.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      regs_r[clr_addr_s] <= {DATA_W{1'b0}};
    end else if (wr_en_s) begin
      regs_r[a3] <= wd3;
    end else begin
      regs_r[a3] <= regs_r[a3];
    end
  end

  // Read port 1: x0 and not-ready read as zero.
  always_comb begin
    rd1 = {DATA_W{1'b0}};
    if (read_en_s && is_writable(a1)) begin
      rd1 = regs_r[a1];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_s && (a1 == a3)) begin
        rd1 = wd3;
      end else begin
        rd1 = regs_r[a1];
      end
`endif
    end else begin
      rd1 = {DATA_W{1'b0}};
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = {DATA_W{1'b0}};
    if (read_en_s && is_writable(a2)) begin
      rd2 = regs_r[a2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_s && (a2 == a3)) begin
        rd2 = wd3;
      end else begin
        rd2 = regs_r[a2];
      end
`endif
    end else begin
      rd2 = {DATA_W{1'b0}};
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized
// traffic, compared against a behavioural model of the register file.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;
  logic        ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model: register contents, ready flag, cleared-count.
  logic [31:0] m_regs [32];
  bit          m_ready;
  int          m_cnt;

  logic [31:0] obs1, obs2;

  reg_file dut (
    .clk   (clk),
    .rst   (rst),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .we3   (we3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value from the model for the currently driven inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!m_ready || rst || a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (we3 && a3 != 5'd0 && a == a3) return wd3;
`endif
    return m_regs[a];
  endfunction

  // Advance the model by one rising edge using the driven inputs.
  task automatic model_edge();
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      m_cnt = m_cnt + 1;
      m_regs[m_cnt] = 32'h0;
      if (m_cnt == 31) m_ready = 1'b1;
    end else if (we3 && a3 != 5'd0) begin
      m_regs[a3] = wd3;
    end
  endtask

  // One clock cycle: drive, check reads/ready mid-cycle, take the edge.
  task automatic cyc(input logic r, input logic we, input logic [4:0] x1,
                     input logic [4:0] x2, input logic [4:0] x3,
                     input logic [31:0] d, input bit chk);
    rst = r; we3 = we; a1 = x1; a2 = x2; a3 = x3; wd3 = d;
    #2;
    obs1 = rd1;
    obs2 = rd2;
    if (chk) begin
      check("rd1", rd1, exp_rd(x1));
      check("rd2", rd2, exp_rd(x2));
      check("ready", {31'b0, ready}, {31'b0, m_ready});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_ready = 1'b0;
    m_cnt   = 0;
    rst = 1'b1; we3 = 1'b0; a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; wd3 = 32'h0;

    // Reset sweep: two reset cycles, then ready low for 30 edges, high at 31.
    cyc(1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b1);
    check("rst_ready", {31'b0, ready}, 32'h0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b1);
    check("ready_at_30", {31'b0, ready}, 32'h0);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
    check("ready_at_31", {31'b0, ready}, 32'h1);
    for (int i = 1; i < 32; i++) begin
      cyc(1'b0, 1'b0, 5'(i), 5'(32 - i), 5'd0, 32'h0, 1'b1);
      check("swept_zero", obs1, 32'h0);
    end

    // Basic write then read on both ports.
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1);
    cyc(1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b1);
    check("basic_rd1", obs1, 32'hDEADBEEF);
    check("basic_rd2", obs2, 32'hDEADBEEF);

    // x0 immunity.
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0, 1'b1);
    check("x0_rd1", obs1, 32'h0);

    // Same-cycle read/write of reg 9.
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h1, 1'b1);
    cyc(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 32'hA5A5A5A5, 1'b1);
`ifdef REG_FILE_BYPASS_EN
    check("same_cycle_rd1", obs1, 32'hA5A5A5A5);
`else
    check("same_cycle_rd1", obs1, 32'h1);
`endif
    cyc(1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0, 1'b1);
    check("after_write_rd1", obs1, 32'hA5A5A5A5);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom, 1'b1);
    end

    // Reset mid-operation, interrupted sweep, write attempt during clear.
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'h11111111, 1'b1);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd2, 32'h22222222, 1'b1);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h33333333, 1'b1);
    cyc(1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b1);
    check("rst_drops_ready", {31'b0, ready}, 32'h0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b1);
    check("midsweep_rst_ready", {31'b0, ready}, 32'h0);
    for (int i = 0; i < 31; i++) begin
      if (i == 2) cyc(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'hFF, 1'b1);
      else        cyc(1'b0, 1'b0, 5'd1, 5'd3, 5'd0, 32'h0, 1'b1);
    end
    check("resweep_ready", {31'b0, ready}, 32'h1);
    cyc(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b1);
    check("reg1_cleared", obs1, 32'h0);
    check("reg2_cleared", obs2, 32'h0);
    cyc(1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0, 1'b1);
    check("reg3_cleared", obs1, 32'h0);
    check("reg7_clear_write_dropped", obs2, 32'h0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), $urandom, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file
